fetch_unit: RTL



---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 82 ++++++++
 rtl/fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, instruction field positions and
// small decode helpers used by the fetch stage.
package cpu_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int TGT_MSB = 25;

    typedef logic [OPC_MSB-OPC_LSB:0] opcode_t;
    typedef logic [TGT_MSB:0]         jmp_target_t;

    localparam opcode_t OP_JMP = 6'h02;

    function automatic opcode_t get_opcode(input logic [DATA_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic jmp_target_t get_jmp_target(input logic [DATA_W-1:0] instr);
        return instr[TGT_MSB:0];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode. Flush beats push and pop;
// when empty the head output keeps the last entry that left the queue.
module fetch_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [W-1:0]     last_q, last_d;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop    = pop & ~empty & ~flush;
    assign do_push   = push & ~flush & (~full | do_pop);
    assign head_data = empty ? last_q : mem_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        last_d  = last_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (!empty) begin
                last_d = mem_q[head_q];
            end
        end else begin
            if (do_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + 1'b1;
                last_d = mem_q[head_q];
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, folds unconditional jumps locally and
// buffers fetched {instr, pc} pairs for decode. Redirects flush and reload.
module fetch_unit #(
    parameter int                ADDR_W      = cpu_pkg::ADDR_W,
    parameter int                DATA_W      = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                QUEUE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    import cpu_pkg::*;

    localparam int ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  jmp_pc;
    logic [ENTRY_W-1:0] head_entry;
    logic               q_full, q_empty;
    logic               pop, fetch, push, is_jmp;

    assign imem_addr = pc_q;
    assign is_jmp    = (get_opcode(imem_instr) == OP_JMP);
    assign jmp_pc    = ADDR_W'(get_jmp_target(imem_instr));

    assign out_valid = ~q_empty;
    assign pop       = out_valid & out_ready;
    assign fetch     = (~q_full | pop) & ~redirect_valid;
    // Jumps are consumed here and never occupy a queue slot.
    assign push      = fetch & ~is_jmp;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fetch) begin
            pc_d = is_jmp ? jmp_pc : pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .W     (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem_instr, pc_q}),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (q_full),
        .empty     (q_empty),
        .head_data (head_entry)
    );

    assign out_instr = head_entry[ENTRY_W-1:ADDR_W];
    assign out_pc    = head_entry[ADDR_W-1:0];

endmodule
